// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: machine width, opcode constants, queue entry type.
// Imported by the fetch stage, its queue, and the fetch/decode interface.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: imem request/response channel, decode handshake and redirect.
// master = fetch stage side, slave = memory/decode/branch-unit side.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr}; push visible at head the cycle after, no bypass.
// No internal backpressure: the caller's credit scheme keeps pushes within capacity.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, queues responses for decode.
// Request-to-instr_valid latency is mem latency + 1; redirect flushes the queue and drops in-flight responses.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic            credit;
  logic            req_fire;
  logic            rsp_live;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Queue slots plus in-flight requests never exceed DEPTH, so every live response has room.
  assign credit   = ({1'b0, count} + {1'b0, out_q}) < (CW+1)'(DEPTH);
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_live = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;
  assign pop      = bus.instr_valid && bus.instr_ready;

  // Once nothing is being dropped, all in-flight requests are sequential from the oldest live one.
  assign push_entry.pc    = pc_q - XLEN'({out_q, 2'b00});
  assign push_entry.instr = bus.imem_rsp_data;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    drop_d = drop_q;
    if (bus.redirect_valid) begin
      pc_d   = word_align(bus.redirect_pc);
      // Everything still in flight (already-stale ones included) is now stale.
      drop_d = out_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (bus.imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_live),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .count      (count),
    .head       (head)
  );

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = !rst && (count != '0);
  assign bus.instr          = rst ? '0 : head.instr;
  assign bus.instr_pc       = rst ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order fixed-latency memory model (data = ~addr).
module tb_fetch_stage;

  logic clk;
  logic rst;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int lat    = 1;
  int nreq   = 0;
  int npop   = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock: record this cycle's handshakes, cross the edge, drive the memory response.
  task automatic tick();
    #2;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend_addr.push_back(bus.imem_req_addr);
      pend_due.push_back(cyc + lat);
      nreq++;
    end
    if (bus.instr_valid && bus.instr_ready) npop++;
    @(posedge clk);
    #1;
    cyc++;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = ~pend_addr[0];
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    pend_addr.delete();
    pend_due.delete();
    tick();
    tick();
    nreq = 0;
    npop = 0;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    int i = 0;
    while (!bus.instr_valid && i < 20) begin
      tick();
      i++;
    end
    check({tag, "_seen"}, {31'd0, bus.instr_valid}, 32'd1);
    check({tag, "_pc"}, bus.instr_pc, exp_pc);
    check({tag, "_instr"}, bus.instr, ~exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    rst = 1'b1;

    // Reset values and streaming at one instruction per cycle.
    lat = 1;
    do_reset();
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
    release_reset();
    check("c0_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("c0_addr", bus.imem_req_addr, 32'h0);
    tick();
    check("c1_addr", bus.imem_req_addr, 32'h4);
    check("c1_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check("c2_addr", bus.imem_req_addr, 32'h8);
    check("c2_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("c2_instr_pc", bus.instr_pc, 32'h0);
    check("c2_instr", bus.instr, 32'hFFFF_FFFF);
    tick();
    check("c3_instr_pc", bus.instr_pc, 32'h4);
    check("c3_addr", bus.imem_req_addr, 32'hC);
    tick();
    check("c4_instr_pc", bus.instr_pc, 32'h8);

    // Decode stalled: queue fills, exactly DEPTH requests, one pop frees one credit.
    bus.instr_ready = 1'b0;
    do_reset();
    release_reset();
    for (int i = 0; i < 8; i++) tick();
    check("full_nreq", nreq, 32'd4);
    check("full_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("full_head_pc", bus.instr_pc, 32'h0);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    #1;
    check("pop1_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("pop1_addr", bus.imem_req_addr, 32'h10);
    check("pop1_head_pc", bus.instr_pc, 32'h4);
    tick();
    tick();
    check("pop1_nreq", nreq, 32'd5);
    check("pop1_refull", {31'd0, bus.imem_req_valid}, 32'd0);

    // Memory stall: address held, nothing issued until ready returns.
    bus.instr_ready    = 1'b1;
    bus.imem_req_ready = 1'b0;
    do_reset();
    release_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_addr", bus.imem_req_addr, 32'h0);
      check("stall_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    end
    check("stall_nreq", nreq, 32'd0);
    bus.imem_req_ready = 1'b1;
    tick();
    check("unstall_nreq", nreq, 32'd1);
    check("unstall_addr", bus.imem_req_addr, 32'h4);

    // Latency 3, redirect with two requests in flight.
    lat = 3;
    do_reset();
    release_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    check("redir_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("redir_r1_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("redir_r1_addr", bus.imem_req_addr, 32'h100);
    wait_valid("redir_first", 32'h100);

    // Back-to-back redirects with stale responses still arriving.
    do_reset();
    release_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    tick();
    bus.redirect_pc    = 32'h400;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("b2b_addr", bus.imem_req_addr, 32'h400);
    wait_valid("b2b_first", 32'h400);

    // Redirect together with a decode pop and an arriving response.
    lat = 1;
    do_reset();
    release_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("rpop_npop", npop, 32'd1);
    check("rpop_empty", {31'd0, bus.instr_valid}, 32'd0);
    check("rpop_addr", bus.imem_req_addr, 32'h200);
    wait_valid("rpop_first", 32'h200);

    // Redirect low bits ignored; PC wraps at the top of the address space.
    do_reset();
    release_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("align_addr", bus.imem_req_addr, 32'h100);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr", bus.imem_req_addr, 32'h0);
    wait_valid("wrap_first", 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
